// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: captures bytes from a level-handshake UART receiver into a
// first-word-fall-through FIFO.
//
// Ports
//   clk         in   clock, rising edge
//   reset       in   synchronous, active-high reset
//   rx_rdy      in   receiver byte-ready level (held until cleared)
//   rx_data     in   received byte, valid while rx_rdy=1
//   rx_rdy_clr  out  clear request to the receiver's ready flag
//   m_data      out  head-of-FIFO byte
//   m_valid     out  m_data valid
//   m_ready     in   consumer accepts m_data
//   count       out  bytes stored, 0..DEPTH
//   overflow    out  sticky: a byte was dropped because the FIFO was full
//   ovf_clr     in   clears overflow (a same-edge drop wins)
module uart_rx_fifo #(
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    output logic              rx_rdy_clr,
    output logic [7:0]        m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W:0]   count,
    input  logic              ovf_clr,
    output logic              overflow
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_CLR = 1'b1
    } state_t;

    state_t              state_q;
    logic                rx_rdy_clr_q;
    logic [ADDR_W-1:0]   wr_ptr_q;
    logic [ADDR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    count_d;
    logic                m_valid_q;
    logic                overflow_q;
    logic [7:0]          mem_q [DEPTH];

    logic push_try;
    logic push;
    logic pop;
    logic full;
    logic drop;

    // Push/pop qualification; a full FIFO still accepts when a pop frees a slot at the same edge.
    always_comb begin
        push_try = (state_q == IDLE) && rx_rdy;
        pop      = (count_q != '0) && m_ready;
        full     = (count_q == CNT_W'(DEPTH));
        push     = push_try && (!full || pop);
        drop     = push_try && !push;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Capture FSM, pointers, occupancy and flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rx_rdy_clr_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            m_valid_q    <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            // rx_rdy_clr tracks the state register so it is high exactly while in WAIT_CLR.
            if (state_q == IDLE) begin
                if (rx_rdy) begin
                    state_q      <= WAIT_CLR;
                    rx_rdy_clr_q <= 1'b1;
                end
            end else begin
                if (!rx_rdy) begin
                    state_q      <= IDLE;
                    rx_rdy_clr_q <= 1'b0;
                end
            end

            if (push) begin
                wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            end

            count_q   <= count_d;
            m_valid_q <= (count_d != '0);

            // Set beats clear when a drop coincides with ovf_clr.
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (ovf_clr) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // Storage array; contents deliberately not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= rx_data;
        end
    end

    assign rx_rdy_clr = rx_rdy_clr_q;
    assign m_valid    = m_valid_q;
    assign m_data     = mem_q[rd_ptr_q];
    assign count      = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus pushes expected bytes into a
// queue once the DUT acknowledges capture; a monitor pops and compares on
// every consumer handshake.
module tb_uart_rx_fifo;

    logic       clk;
    logic       reset;
    logic       rx_rdy;
    logic [7:0] rx_data;
    logic       rx_rdy_clr;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic [4:0] count;
    logic       ovf_clr;
    logic       overflow;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q [$];

    uart_rx_fifo #(.ADDR_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_rdy     (rx_rdy),
        .rx_data    (rx_data),
        .rx_rdy_clr (rx_rdy_clr),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .count      (count),
        .ovf_clr    (ovf_clr),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: a pop happens at the next rising edge, so compare the head now.
    always @(negedge clk) begin
        if (!reset && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL pop_unexpected: got 0x%0h expected no data at %0t", m_data, $time);
            end else begin
                check("pop_data", 32'(m_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One receiver handshake; rx_rdy is held one cycle past the first rx_rdy_clr.
    task automatic send_byte(input logic [7:0] b, input bit accepted, output int clr_cyc);
        int n;
        tick();
        rx_rdy  = 1'b1;
        rx_data = b;
        n = 0;
        do begin
            tick();
            n++;
        end while (!rx_rdy_clr && n < 20);
        clr_cyc = 0;
        if (!rx_rdy_clr) begin
            n_checks++;
            n_errors++;
            $display("FAIL clr_timeout: got rx_rdy_clr=0 expected 1 at %0t", $time);
        end else begin
            clr_cyc = 1;
            if (accepted) exp_q.push_back(b);
        end
        tick();
        if (rx_rdy_clr) clr_cyc++;
        rx_rdy = 1'b0;
        n = 0;
        while (rx_rdy_clr && n < 20) begin
            tick();
            if (rx_rdy_clr) clr_cyc++;
            n++;
        end
    endtask

    task automatic pop_one();
        tick();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        tick();
        m_ready = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (count != 5'd0 && n < 100);
        m_ready = 1'b0;
        check(name, 32'(count), 32'd0);
        check({name, "_q_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cc;
        reset   = 1'b1;
        rx_rdy  = 1'b0;
        rx_data = 8'h00;
        m_ready = 1'b0;
        ovf_clr = 1'b0;
        repeat (3) tick();
        check("rst_count",    32'(count),      32'd0);
        check("rst_valid",    32'(m_valid),    32'd0);
        check("rst_clr",      32'(rx_rdy_clr), 32'd0);
        check("rst_overflow", 32'(overflow),   32'd0);
        reset = 1'b0;

        // m_ready while empty does nothing
        m_ready = 1'b1;
        repeat (3) tick();
        m_ready = 1'b0;
        check("empty_ready_count", 32'(count), 32'd0);

        // Single byte
        send_byte(8'hA5, 1'b1, cc);
        check("single_clr_cycles", 32'(cc),      32'd2);
        check("single_count",      32'(count),   32'd1);
        check("single_valid",      32'(m_valid), 32'd1);
        check("single_data",       32'(m_data),  32'hA5);
        drain("single_drain");

        // Order and wrap: pop after every 4th push
        for (int i = 0; i < 20; i++) begin
            send_byte(8'(i), 1'b1, cc);
            if ((i % 4) == 3) pop_one();
        end
        check("wrap_count",    32'(count),    32'd15);
        check("wrap_overflow", 32'(overflow), 32'd0);
        drain("wrap_drain");

        // Fill, then one dropped byte
        for (int i = 0; i < 16; i++) send_byte(8'(8'h80 + i), 1'b1, cc);
        send_byte(8'h90, 1'b0, cc);
        check("full_count",    32'(count),    32'd16);
        check("full_overflow", 32'(overflow), 32'd1);
        check("full_clr_cyc",  32'(cc),       32'd2);

        // Drop and ovf_clr at the same edge: set wins
        tick();
        rx_rdy  = 1'b1;
        rx_data = 8'hEE;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("contend_overflow", 32'(overflow), 32'd1);
        check("contend_count",    32'(count),    32'd16);
        tick();
        rx_rdy = 1'b0;
        tick();
        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Full with simultaneous push and pop
        rx_rdy  = 1'b1;
        rx_data = 8'h77;
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("simul_count",    32'(count),      32'd16);
        check("simul_overflow", 32'(overflow),   32'd0);
        check("simul_clr",      32'(rx_rdy_clr), 32'd1);
        exp_q.push_back(8'h77);
        tick();
        rx_rdy = 1'b0;
        tick();
        check("simul_clr_low", 32'(rx_rdy_clr), 32'd0);
        drain("full_drain");

        // Mid-operation reset while in WAIT_CLR
        for (int i = 0; i < 5; i++) send_byte(8'(8'h40 + i), 1'b1, cc);
        tick();
        rx_rdy  = 1'b1;
        rx_data = 8'h5C;
        tick();
        check("pre_rst_count", 32'(count),      32'd6);
        check("pre_rst_clr",   32'(rx_rdy_clr), 32'd1);
        reset = 1'b1;
        exp_q.delete();
        tick();
        reset = 1'b0;
        check("mid_rst_count",    32'(count),      32'd0);
        check("mid_rst_valid",    32'(m_valid),    32'd0);
        check("mid_rst_clr",      32'(rx_rdy_clr), 32'd0);
        check("mid_rst_overflow", 32'(overflow),   32'd0);

        // rx_rdy still high after reset is a new byte
        rx_data = 8'h3C;
        tick();
        check("post_rst_count", 32'(count),      32'd1);
        check("post_rst_clr",   32'(rx_rdy_clr), 32'd1);
        check("post_rst_data",  32'(m_data),     32'h3C);
        exp_q.push_back(8'h3C);
        rx_rdy = 1'b0;
        tick();
        drain("post_rst_drain");

        repeat (4) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter ADDR_W, default 4, FIFO address width; DEPTH = 2**ADDR_W entries; legal range 1..8.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 reset  in  1  reset, synchronous, active-high.
REQ-004 rx_rdy  in  1  byte-ready level from UART receiver; held high until cleared.
REQ-005 rx_data  in  8  received byte; valid while rx_rdy=1.
REQ-006 rx_rdy_clr  out  1  clear request to receiver's ready flag.
REQ-007 m_data  out  8  head-of-FIFO byte.
REQ-008 m_valid  out  1  m_data valid.
REQ-009 m_ready  in  1  consumer accepts m_data.
REQ-010 count  out  ADDR_W+1  bytes currently stored, 0..DEPTH.
REQ-011 overflow  out  1  sticky flag: a byte was dropped because the FIFO was full.
REQ-012 ovf_clr  in  1  clears overflow.

Function
REQ-013 The capture FSM SHALL have two states, IDLE and WAIT_CLR, held in a register.
REQ-014 In IDLE with rx_rdy=1, the block SHALL push rx_data at that edge if room exists (REQ-019) and SHALL move to WAIT_CLR.
REQ-015 In WAIT_CLR, the block SHALL push nothing and SHALL return to IDLE on the first edge at which rx_rdy=0.
REQ-016 rx_rdy_clr SHALL equal 1 exactly while state=WAIT_CLR (registered, glitch-free); a single receiver byte SHALL be pushed at most once.
REQ-017 Storage SHALL be a DEPTH x 8 array with ADDR_W-bit write and read pointers, each incremented by 1 per push/pop and wrapping modulo DEPTH.
REQ-018 The FIFO SHALL be first-word-fall-through: m_valid = (count != 0), m_data = entry at read pointer; m_data is don't-care when m_valid=0.
REQ-019 A push SHALL be accepted when count < DEPTH, or when count = DEPTH and a pop occurs at the same edge.
REQ-020 A pop SHALL occur at an edge where m_valid=1 and m_ready=1; m_ready while empty SHALL have no effect.
REQ-021 count SHALL increment on push only, decrement on pop only, and remain unchanged on simultaneous push and pop.
REQ-022 A push attempt that is not accepted SHALL drop the byte, leave the pointers and count unchanged, set overflow to 1, and still enter WAIT_CLR.
REQ-023 overflow SHALL clear on an edge with ovf_clr=1; if a drop occurs at the same edge, set SHALL win.
REQ-024 Latency: with rx_rdy rising before cycle N while the FIFO is empty, m_valid=1 and m_data=rx_data SHALL hold from cycle N+1.
REQ-025 Bytes SHALL be delivered in arrival order with no loss while count < DEPTH.

Reset
REQ-026 With reset=1 at an edge, the block SHALL set state=IDLE, pointers=0, count=0, overflow=0, rx_rdy_clr=0, and m_valid=0; array contents are not reset.
REQ-027 Reset SHALL override all other inputs, including during WAIT_CLR or a simultaneous push/pop.
REQ-028 After reset, an rx_rdy already high SHALL be treated as a new byte.

Verification
REQ-029 Single byte: rx_rdy=1 with rx_data=0xA5 held until rx_rdy_clr is seen plus one cycle -> exactly one push, count=1, m_valid=1, m_data=0xA5, rx_rdy_clr high for 2 cycles.
REQ-030 Order and wrap (ADDR_W=4): push 0x00..0x13 while popping after every 4th push, then drain -> output sequence 0x00..0x13, pointers wrap, count returns to 0.
REQ-031 Full and overflow: 17 pushes with m_ready=0 -> count=16, overflow=1, 17th byte absent, drain yields the first 16 bytes; ovf_clr=1 -> overflow=0.
REQ-032 Full with simultaneous push and pop: count=16, push with m_ready=1 at the same edge -> byte accepted, count stays 16, overflow stays 0.
REQ-033 Clear contention: ovf_clr=1 at the same edge as a dropped push -> overflow=1.
REQ-034 Mid-operation reset: count=5, state=WAIT_CLR, assert reset one cycle -> count=0, m_valid=0, rx_rdy_clr=0, overflow=0 at the next cycle.
